// File: rtl/mult_arbiter_if.sv
// Requester-side handshake bundle for mult_arbiter.
// slave: arbiter side. master: requester side.
interface mult_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [18*NREQ-1:0]   req_a;
  logic [18*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic signed [35:0]   rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin share of one pipelined 18x18 signed multiplier.
// Ports: clk, rst, bus (req/rsp), mult_* pins, busy.
module mult_arbiter #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  mult_arbiter_if.slave     bus,
  output logic [17:0]       mult_a,
  output logic [17:0]       mult_b,
  output logic              mult_en,
  output logic              mult_rst,
  input  logic [35:0]       mult_o,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      nxt;
  logic               issue;
  int                 j;
  logic [LATENCY-1:0] tv;
  logic [IW-1:0]      to [LATENCY];
  logic               inflight;

  // first valid requester searching ptr, ptr+1, ... (mod NREQ)
  always_comb begin
    issue = 1'b0;
    gidx  = ptr;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!issue && bus.req_valid[j]) begin
        issue = 1'b1;
        gidx  = IW'(j);
      end
    end
    if (rst) issue = 1'b0;
  end

  assign nxt = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;

  assign bus.req_ready = issue ? (NREQ'(1) << gidx) : '0;

  // with no grant gidx == ptr, so operands stay a legal slice
  assign mult_a = bus.req_a[18*int'(gidx) +: 18];
  assign mult_b = bus.req_b[18*int'(gidx) +: 18];

  assign inflight = |tv;
  assign mult_en  = rst | issue | inflight;
  assign mult_rst = rst;
  assign busy     = inflight & ~rst;

  assign bus.rsp_valid = (tv[LATENCY-1] && !rst)
                       ? (NREQ'(1) << to[LATENCY-1]) : '0;
  assign bus.rsp_data  = mult_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      tv  <= '0;
    end else begin
      if (issue) ptr <= nxt;
      // tags march in lockstep with the multiplier's clock-enable
      if (mult_en) begin
        tv[0] <= issue;
        for (int k = 1; k < LATENCY; k++) begin
          tv[k] <= tv[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mult_en) begin
      to[0] <= gidx;
      for (int k = 1; k < LATENCY; k++) begin
        to[k] <= to[k-1];
      end
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural DSP model.
// Directed test-plan cases followed by randomized traffic and resets.
module tb_mult_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(NREQ)) bus ();

  logic [17:0] mult_a;
  logic [17:0] mult_b;
  logic        mult_en;
  logic        mult_rst;
  logic [35:0] mult_o;
  logic        busy;

  mult_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_en  (mult_en),
    .mult_rst (mult_rst),
    .mult_o   (mult_o),
    .busy     (busy)
  );

  // DSP primitive: product of captured operands appears LAT edges later
  logic signed [35:0] p [LAT];
  always_ff @(posedge clk) begin
    if (mult_rst) begin
      for (int k = 0; k < LAT; k++) p[k] <= '0;
    end else if (mult_en) begin
      p[0] <= $signed(mult_a) * $signed(mult_b);
      for (int k = 1; k < LAT; k++) p[k] <= p[k-1];
    end
  end
  assign mult_o = p[LAT-1];

  typedef struct {
    int     due;
    int     owner;
    longint prod;
  } exp_t;

  exp_t            q [$];
  int              cyc = 0;
  int              mptr = 0;
  int              compared = 0;
  int              mismatched = 0;
  logic [NREQ-1:0] acc = '0;

  task automatic chk(string nm, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: mid-cycle, compare every output with the model
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_ready", longint'(bus.req_ready), 0);
        chk("rst_rsp_valid", longint'(bus.rsp_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_mult_en", longint'(mult_en), 1);
        chk("rst_mult_rst", longint'(mult_rst), 1);
        q.delete();
        mptr = 0;
        acc  = '0;
      end else begin
        int     eg;
        bit     ebusy;
        longint er;
        eg = -1;
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (mptr + k) % NREQ;
          if (eg < 0 && bus.req_valid[idx]) eg = idx;
        end
        ebusy = (q.size() > 0);
        er = (eg >= 0) ? (longint'(1) << eg) : 0;
        chk("req_ready", longint'(bus.req_ready), er);
        chk("busy", longint'(busy), longint'(ebusy));
        chk("mult_en", longint'(mult_en),
            longint'((eg >= 0) || ebusy));
        chk("mult_rst", longint'(mult_rst), 0);
        if (q.size() > 0 && q[0].due == cyc) begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_valid", longint'(bus.rsp_valid),
              longint'(1) << e.owner);
          chk("rsp_data", longint'(bus.rsp_data), e.prod);
        end else begin
          chk("rsp_idle", longint'(bus.rsp_valid), 0);
        end
        if (eg >= 0) begin
          logic signed [17:0] a;
          logic signed [17:0] b;
          exp_t               n;
          a = bus.req_a[18*eg +: 18];
          b = bus.req_b[18*eg +: 18];
          n.due   = cyc + LAT;
          n.owner = eg;
          n.prod  = longint'(a) * longint'(b);
          q.push_back(n);
          mptr = (eg + 1) % NREQ;
        end
        acc = bus.req_ready & bus.req_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(int i, int a, int b);
    bus.req_a[18*i +: 18] = 18'(a);
    bus.req_b[18*i +: 18] = 18'(b);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // single op
    put(0, 3, -5); bus.req_valid = 2'b01; step();
    bus.req_valid = '0; repeat (6) step();

    // back-to-back from requester 1
    bus.req_valid = 2'b10;
    put(1, 1, 1); step();
    put(1, 2, 2); step();
    put(1, 3, 3); step();
    bus.req_valid = '0; repeat (5) step();

    // contention from reset
    rst = 1'b1;
    put(0, 10, 10); put(1, -7, 6);
    bus.req_valid = 2'b11;
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();
    bus.req_valid = '0; repeat (5) step();

    // signed corners
    bus.req_valid = 2'b01;
    put(0, -131072, -131072); step();
    put(0, 131071, -131072); step();
    put(0, 0, -1); step();
    bus.req_valid = '0; repeat (5) step();

    // reset mid-flight
    put(0, 5, 6); put(1, 7, 8);
    bus.req_valid = 2'b11; repeat (2) step();
    bus.req_valid = '0; rst = 1'b1; step();
    rst = 1'b0;
    put(0, 9, 9); put(1, -4, 11);
    bus.req_valid = 2'b11; repeat (2) step();
    bus.req_valid = '0; repeat (6) step();

    // idle
    repeat (10) step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          put(i, int'($urandom), int'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      rst = 1'b0;
    end
    bus.req_valid = '0;
    repeat (8) step();
    chk("drain", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
